// File: rtl/odd_operand_fetch.sv
// Register-fetch / forwarding stage feeding the odd pipe: resolves RA/RB/RC from the
// register file or the youngest matching forwarding stage, stalls on unready results.
module odd_operand_fetch #(
   parameter int REG_ADDR_WD = 7,
   parameter int REG_DATA_WD = 128,
   parameter int NUM_FWD     = 6,
   parameter int CNT_WD      = 16,
   parameter int OPC_WD      = 8,
   parameter int IMM_WD      = 18,
   parameter logic [OPC_WD-1:0] NOP_OPC = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic [OPC_WD-1:0]              in_opcode,
   input  logic [REG_ADDR_WD-1:0]         in_ra_addr,
   input  logic [REG_ADDR_WD-1:0]         in_rb_addr,
   input  logic [REG_ADDR_WD-1:0]         in_rc_addr,
   input  logic                           in_ra_use,
   input  logic                           in_rb_use,
   input  logic                           in_rc_use,
   input  logic [REG_ADDR_WD-1:0]         in_rt_addr,
   input  logic                           in_rt_we,
   input  logic [IMM_WD-1:0]              in_imm,
   input  logic [REG_DATA_WD-1:0]         rf_ra_data,
   input  logic [REG_DATA_WD-1:0]         rf_rb_data,
   input  logic [REG_DATA_WD-1:0]         rf_rc_data,
   input  logic [NUM_FWD*REG_ADDR_WD-1:0] fwd_addr,
   input  logic [NUM_FWD*REG_DATA_WD-1:0] fwd_data,
   input  logic [NUM_FWD-1:0]             fwd_we,
   input  logic [NUM_FWD-1:0]             fwd_rdy,
   input  logic                           flush,
   output logic                           stall,
   output logic                           out_valid,
   output logic [OPC_WD-1:0]              out_opcode,
   output logic [REG_DATA_WD-1:0]         out_RA,
   output logic [REG_DATA_WD-1:0]         out_RB,
   output logic [REG_DATA_WD-1:0]         out_RC,
   output logic [REG_ADDR_WD-1:0]         out_RT_addr,
   output logic                           out_rt_we,
   output logic [IMM_WD-1:0]              out_imm,
   output logic [CNT_WD-1:0]              stall_cnt
);

   logic [REG_ADDR_WD-1:0] src_addr [3];
   logic [REG_DATA_WD-1:0] src_rf   [3];
   logic [REG_DATA_WD-1:0] src_opnd [3];
   logic [2:0]             src_use;
   logic [2:0]             src_hit;
   logic [2:0]             src_haz;

   always_comb begin
      src_addr[0] = in_ra_addr;
      src_addr[1] = in_rb_addr;
      src_addr[2] = in_rc_addr;
      src_rf[0]   = rf_ra_data;
      src_rf[1]   = rf_rb_data;
      src_rf[2]   = rf_rc_data;
      src_use     = {in_rc_use, in_rb_use, in_ra_use};
   end

   // The output register's result is never ready yet, so it ranks as the youngest producer.
   always_comb begin
      for (int s = 0; s < 3; s++) begin
         src_opnd[s] = src_rf[s];
         src_hit[s]  = 1'b0;
         src_haz[s]  = 1'b0;
         if (src_use[s]) begin
            if (out_valid && out_rt_we && (out_RT_addr == src_addr[s])) begin
               src_hit[s] = 1'b1;
               src_haz[s] = 1'b1;
            end
            for (int i = 0; i < NUM_FWD; i++) begin
               if (!src_hit[s] && fwd_we[i] &&
                   (fwd_addr[i*REG_ADDR_WD +: REG_ADDR_WD] == src_addr[s])) begin
                  src_hit[s] = 1'b1;
                  if (fwd_rdy[i])
                     src_opnd[s] = fwd_data[i*REG_DATA_WD +: REG_DATA_WD];
                  else
                     src_haz[s] = 1'b1;
               end
            end
         end
      end
   end

   assign stall = rst && in_valid && !flush && (|src_haz);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid   <= 1'b0;
         out_rt_we   <= 1'b0;
         out_opcode  <= NOP_OPC;
         out_RA      <= '0;
         out_RB      <= '0;
         out_RC      <= '0;
         out_RT_addr <= '0;
         out_imm     <= '0;
         stall_cnt   <= '0;
      end else begin
         if (flush || stall) begin
            out_valid  <= 1'b0;
            out_rt_we  <= 1'b0;
            out_opcode <= NOP_OPC;
         end else begin
            out_valid   <= in_valid;
            out_rt_we   <= in_rt_we && in_valid;
            out_opcode  <= in_opcode;
            out_RA      <= src_opnd[0];
            out_RB      <= src_opnd[1];
            out_RC      <= src_opnd[2];
            out_RT_addr <= in_rt_addr;
            out_imm     <= in_imm;
         end
         if (stall && (stall_cnt != {CNT_WD{1'b1}}))
            stall_cnt <= stall_cnt + CNT_WD'(1);
      end
   end

endmodule

// File: tb/tb_odd_operand_fetch.sv
// Bench for odd_operand_fetch: producer-list reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_odd_operand_fetch;
   localparam int AW = 7;
   localparam int DW = 128;
   localparam int NF = 6;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [7:0]      in_opcode;
   logic [AW-1:0]   in_ra_addr, in_rb_addr, in_rc_addr, in_rt_addr;
   logic            in_ra_use, in_rb_use, in_rc_use, in_rt_we;
   logic [17:0]     in_imm;
   logic [DW-1:0]   rf_ra_data, rf_rb_data, rf_rc_data;
   logic [NF*AW-1:0] fwd_addr;
   logic [NF*DW-1:0] fwd_data;
   logic [NF-1:0]   fwd_we, fwd_rdy;
   logic            flush;
   logic            stall, out_valid, out_rt_we;
   logic [7:0]      out_opcode;
   logic [DW-1:0]   out_RA, out_RB, out_RC;
   logic [AW-1:0]   out_RT_addr;
   logic [17:0]     out_imm;
   logic [CW-1:0]   stall_cnt;

   int checks = 0;
   int errors = 0;

   odd_operand_fetch dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
      .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
      .in_ra_use(in_ra_use), .in_rb_use(in_rb_use), .in_rc_use(in_rc_use),
      .in_rt_addr(in_rt_addr), .in_rt_we(in_rt_we), .in_imm(in_imm),
      .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_rc_data(rf_rc_data),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_we(fwd_we), .fwd_rdy(fwd_rdy),
      .flush(flush), .stall(stall), .out_valid(out_valid), .out_opcode(out_opcode),
      .out_RA(out_RA), .out_RB(out_RB), .out_RC(out_RC), .out_RT_addr(out_RT_addr),
      .out_rt_we(out_rt_we), .out_imm(out_imm), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic            m_valid, m_we;
   logic [7:0]      m_opc;
   logic [AW-1:0]   m_rt;
   logic [17:0]     m_imm;
   logic [DW-1:0]   m_ra, m_rb, m_rc;
   logic [CW-1:0]   m_cnt;

   // Walk the producers youngest-first; the first one writing this address decides.
   function automatic logic [DW-1:0] resolve(input logic [AW-1:0] a, input logic u,
                                             input logic [DW-1:0] rf, output logic haz);
      logic [AW-1:0] p_addr [$];
      logic          p_rdy  [$];
      logic [DW-1:0] p_data [$];
      haz = 1'b0;
      if (!u) return rf;
      if (m_valid && m_we) begin
         p_addr.push_back(m_rt); p_rdy.push_back(1'b0); p_data.push_back('0);
      end
      for (int i = 0; i < NF; i++)
         if (fwd_we[i]) begin
            p_addr.push_back(fwd_addr[i*AW +: AW]);
            p_rdy.push_back(fwd_rdy[i]);
            p_data.push_back(fwd_data[i*DW +: DW]);
         end
      for (int k = 0; k < p_addr.size(); k++)
         if (p_addr[k] == a) begin
            haz = !p_rdy[k];
            return p_rdy[k] ? p_data[k] : rf;
         end
      return rf;
   endfunction

   function automatic void model_eval(output logic stl, output logic [DW-1:0] a,
                                      output logic [DW-1:0] b, output logic [DW-1:0] c);
      logic ha, hb, hc;
      a = resolve(in_ra_addr, in_ra_use, rf_ra_data, ha);
      b = resolve(in_rb_addr, in_rb_use, rf_rb_data, hb);
      c = resolve(in_rc_addr, in_rc_use, rf_rc_data, hc);
      stl = rst && in_valid && !flush && (ha || hb || hc);
   endfunction

   always @(posedge clk or negedge rst) begin
      logic stl;
      logic [DW-1:0] a, b, c;
      if (!rst) begin
         m_valid <= 1'b0; m_we <= 1'b0; m_opc <= '0; m_rt <= '0; m_imm <= '0;
         m_ra <= '0; m_rb <= '0; m_rc <= '0; m_cnt <= '0;
      end else begin
         model_eval(stl, a, b, c);
         if (flush || stl) begin
            m_valid <= 1'b0; m_we <= 1'b0; m_opc <= '0;
         end else begin
            m_valid <= in_valid; m_we <= in_valid && in_rt_we; m_opc <= in_opcode;
            m_rt <= in_rt_addr; m_imm <= in_imm; m_ra <= a; m_rb <= b; m_rc <= c;
         end
         if (stl && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      end
   end

   always @(negedge clk) begin
      logic stl;
      logic [DW-1:0] a, b, c;
      model_eval(stl, a, b, c);
      chk("stall", DW'(stall), DW'(stl));
      chk("out_valid", DW'(out_valid), DW'(m_valid));
      chk("out_rt_we", DW'(out_rt_we), DW'(m_we));
      chk("out_opcode", DW'(out_opcode), DW'(m_opc));
      chk("stall_cnt", DW'(stall_cnt), DW'(m_cnt));
      if (m_valid) begin
         chk("out_RA", out_RA, m_ra);
         chk("out_RB", out_RB, m_rb);
         chk("out_RC", out_RC, m_rc);
         chk("out_RT_addr", DW'(out_RT_addr), DW'(m_rt));
         chk("out_imm", DW'(out_imm), DW'(m_imm));
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      in_valid = 0; in_opcode = '0; in_imm = '0;
      in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0; in_rt_addr = '0;
      in_ra_use = 0; in_rb_use = 0; in_rc_use = 0; in_rt_we = 0;
      rf_ra_data = '0; rf_rb_data = '0; rf_rc_data = '0;
      fwd_addr = '0; fwd_data = '0; fwd_we = '0; fwd_rdy = '0; flush = 0;
   endtask

   task automatic set_fwd(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic we, input logic rdy);
      fwd_addr[i*AW +: AW] = a;
      fwd_data[i*DW +: DW] = d;
      fwd_we[i]  = we;
      fwd_rdy[i] = rdy;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      #1 rst = 1'b0;
      #1;
      chk("rst out_valid", DW'(out_valid), '0);
      chk("rst stall_cnt", DW'(stall_cnt), '0);
      chk("rst out_opcode", DW'(out_opcode), '0);
      cyc();
      rst = 1'b1;

      // no hazard: register-file operand
      in_valid = 1; in_opcode = 8'h21; in_ra_addr = 7'd5; in_ra_use = 1;
      rf_ra_data = {16{8'h11}}; in_rt_addr = 7'd30; in_rt_we = 1; in_imm = 18'h2A5A5;
      rf_rb_data = {16{8'h22}};
      #1 chk("t1 stall", DW'(stall), '0);
      cyc();
      chk("t1 out_valid", DW'(out_valid), DW'(1));
      chk("t1 out_RA", out_RA, {16{8'h11}});
      chk("t1 out_imm", DW'(out_imm), DW'(18'h2A5A5));

      // youngest of two ready producers wins
      idle(); cyc();
      in_valid = 1; in_opcode = 8'h22; in_rb_addr = 7'd9; in_rb_use = 1;
      rf_rb_data = {16{8'h99}};
      set_fwd(0, 7'd9, {16{8'hAA}}, 1, 1);
      set_fwd(3, 7'd9, {16{8'hBB}}, 1, 1);
      cyc();
      chk("t2 out_RB", out_RB, {16{8'hAA}});

      // not-ready producer stalls until ready
      idle(); cyc();
      in_valid = 1; in_opcode = 8'h23; in_rc_addr = 7'd12; in_rc_use = 1;
      set_fwd(1, 7'd12, {16{8'hC3}}, 1, 0);
      #1 chk("t3 stall", DW'(stall), DW'(1));
      cyc();
      chk("t3 bubble", DW'(out_valid), '0);
      chk("t3 stall_cnt", DW'(stall_cnt), DW'(1));
      fwd_rdy[1] = 1;
      #1 chk("t3 stall drop", DW'(stall), '0);
      cyc();
      chk("t3 out_RC", out_RC, {16{8'hC3}});

      // back-to-back dependency through the output register
      idle(); cyc();
      in_valid = 1; in_opcode = 8'h33; in_rt_addr = 7'd20; in_rt_we = 1;
      cyc();
      idle();
      in_valid = 1; in_opcode = 8'h34; in_ra_addr = 7'd20; in_ra_use = 1;
      rf_ra_data = {16{8'h55}};
      #1 chk("t4 stall", DW'(stall), DW'(1));
      cyc();
      set_fwd(0, 7'd20, {16{8'hCC}}, 1, 1);
      #1 chk("t4 fwd stall", DW'(stall), '0);
      cyc();
      chk("t4 out_RA", out_RA, {16{8'hCC}});

      // youngest not ready while an older stage is ready: still a hazard
      idle(); cyc();
      in_valid = 1; in_rb_addr = 7'd9; in_rb_use = 1;
      set_fwd(0, 7'd9, {16{8'hAA}}, 1, 0);
      set_fwd(3, 7'd9, {16{8'hBB}}, 1, 1);
      #1 chk("t5 stall", DW'(stall), DW'(1));
      cyc();

      // flush overrides a hazard; flush kills a plain instruction
      idle(); cyc();
      in_valid = 1; in_ra_addr = 7'd7; in_ra_use = 1; flush = 1;
      set_fwd(2, 7'd7, {16{8'h77}}, 1, 0);
      #1 chk("t6 flush stall", DW'(stall), '0);
      cyc();
      chk("t6 out_valid", DW'(out_valid), '0);
      idle(); in_valid = 1; in_opcode = 8'h40;
      cyc();
      in_opcode = 8'h41; flush = 1;
      cyc();
      chk("t6 flush plain", DW'(out_valid), '0);

      // address 0, RA==RB==RC forwarded from s6
      idle(); cyc();
      in_valid = 1; in_ra_use = 1; in_rb_use = 1; in_rc_use = 1;
      rf_ra_data = {16{8'h01}}; rf_rb_data = {16{8'h02}}; rf_rc_data = {16{8'h03}};
      set_fwd(4, 7'd0, {16{8'hDD}}, 1, 1);
      cyc();
      chk("t7 out_RA", out_RA, {16{8'hDD}});
      chk("t7 out_RB", out_RB, {16{8'hDD}});
      chk("t7 out_RC", out_RC, {16{8'hDD}});

      // asynchronous reset mid-operation
      idle(); in_valid = 1; in_rt_addr = 7'd3; in_rt_we = 1;
      cyc();
      idle();
      in_valid = 1; in_ra_addr = 7'd3; in_ra_use = 1;
      #1 rst = 1'b0;
      #1;
      chk("t8 out_valid", DW'(out_valid), '0);
      chk("t8 out_rt_we", DW'(out_rt_we), '0);
      chk("t8 stall_cnt", DW'(stall_cnt), '0);
      chk("t8 stall", DW'(stall), '0);
      cyc();
      rst = 1'b1;
      idle(); cyc();

      // saturation
      in_valid = 1; in_ra_addr = 7'd3; in_ra_use = 1;
      set_fwd(0, 7'd3, {16{8'h33}}, 1, 0);
      repeat (65535) @(posedge clk);
      #1 chk("t9 sat", DW'(stall_cnt), DW'(16'hFFFF));
      cyc();
      chk("t9 sat hold", DW'(stall_cnt), DW'(16'hFFFF));

      idle(); cyc(); cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
